// File: rtl/traffic_pkg.sv
// ----------------------------------------------------------------------------
// traffic_pkg
// Shared definitions for the parametrised highway / country-road controller:
//   - lamp drive codes (RED / YELLOW / GREEN)
//   - 3-bit controller state encodings (also exported on the debug phase port)
//   - lamp decode helper used by the controller's output logic
// No ports (package).
// ----------------------------------------------------------------------------
package traffic_pkg;

   // Lamp drive codes
   localparam logic [1:0] RED    = 2'd0;
   localparam logic [1:0] YELLOW = 2'd1;
   localparam logic [1:0] GREEN  = 2'd2;

   // Controller states; encodings 6 and 7 are unused
   typedef enum logic [2:0] {
      HG  = 3'd0,   // highway green
      HY  = 3'd1,   // highway yellow
      AR1 = 3'd2,   // all red, clearing toward country green
      CG  = 3'd3,   // country green
      CY  = 3'd4,   // country yellow
      AR2 = 3'd5    // all red, clearing toward highway green
   } state_t;

   typedef struct packed {
      logic [1:0] hwy;
      logic [1:0] cntry;
   } lamps_t;

   // Moore lamp decode. Unused encodings fall into the HG lamp pattern so a
   // corrupted state register never shows a conflicting pair of greens.
   function automatic lamps_t decode_lamps(input logic [2:0] s);
      lamps_t l;
      l.hwy   = GREEN;
      l.cntry = RED;
      case (s)
         HY:      begin l.hwy = YELLOW; l.cntry = RED;    end
         AR1:     begin l.hwy = RED;    l.cntry = RED;    end
         CG:      begin l.hwy = RED;    l.cntry = GREEN;  end
         CY:      begin l.hwy = RED;    l.cntry = YELLOW; end
         AR2:     begin l.hwy = RED;    l.cntry = RED;    end
         default: begin l.hwy = GREEN;  l.cntry = RED;    end
      endcase
      return l;
   endfunction

endpackage

// File: rtl/traffic_signal_controller_param_if.sv
// ----------------------------------------------------------------------------
// traffic_signal_controller_param_if
// Bundles the sensor input and the lamp / monitor outputs of the controller.
//   X       : country-road car present (sensor side -> controller)
//   hwy     : highway lamp code        (controller -> lamp drivers)
//   cntry   : country lamp code        (controller -> lamp drivers)
//   phase   : current state encoding   (controller -> debug / monitoring)
//   timeout : one-cycle pulse when country green was cut short by timeout
// Modports:
//   master : sensor / lamp-driver side (drives X, observes the rest)
//   slave  : controller side
// ----------------------------------------------------------------------------
interface traffic_signal_controller_param_if;
   import traffic_pkg::*;

   logic       X;
   logic [1:0] hwy;
   logic [1:0] cntry;
   logic [2:0] phase;
   logic       timeout;

   modport master (
      output X,
      input  hwy,
      input  cntry,
      input  phase,
      input  timeout
   );

   modport slave (
      input  X,
      output hwy,
      output cntry,
      output phase,
      output timeout
   );

endinterface

// File: rtl/phase_timer.sv
// ----------------------------------------------------------------------------
// phase_timer
// Saturating cycle counter that measures how long the controller has been in
// its current state. It reads 0 in the first cycle of every state.
// Ports:
//   clock   : rising-edge clock
//   clear_n : asynchronous active-low reset (count -> 0)
//   restart : the state register changes on this edge; count returns to 0
//   count   : cycles spent in the current state, saturating at all-ones
// ----------------------------------------------------------------------------
module phase_timer #(
   parameter int CNT_W = 8
) (
   input  logic             clock,
   input  logic             clear_n,
   input  logic             restart,
   output logic [CNT_W-1:0] count
);

   localparam logic [CNT_W-1:0] L_SAT = '1;

   logic [CNT_W-1:0] r_count;

   // Saturation keeps ">= threshold" compares true during long dwells
   // instead of wrapping back below them.
   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) begin
         r_count <= '0;
      end else if (restart) begin
         r_count <= '0;
      end else if (r_count != L_SAT) begin
         r_count <= r_count + CNT_W'(1);
      end
   end

   assign count = r_count;

endmodule

// File: rtl/traffic_signal_controller_param.sv
// ----------------------------------------------------------------------------
// traffic_signal_controller_param
// Highway / country-road traffic-light controller. A single phase timer
// replaces chained wait states; yellow, clearance, minimum highway green and
// maximum country green are all parameters. The country green timeout stops
// a stuck sensor from starving the highway.
// Ports:
//   clock   : rising-edge clock
//   clear_n : asynchronous active-low reset (highway green, timer cleared)
//   bus     : slave side of traffic_signal_controller_param_if
//             (X in; hwy, cntry, phase, timeout out)
// Parameters:
//   CNT_W           : phase timer width
//   Y2R_DELAY       : cycles in each yellow phase (>= 1)
//   R2G_DELAY       : all-red clearance cycles (>= 1)
//   HWY_MIN_GREEN   : minimum highway green cycles before X is honoured (>= 1)
//   CNTRY_MAX_GREEN : maximum country green cycles; 0 disables the timeout
// ----------------------------------------------------------------------------
module traffic_signal_controller_param
   import traffic_pkg::*;
#(
   parameter int CNT_W           = 8,
   parameter int Y2R_DELAY       = 3,
   parameter int R2G_DELAY       = 2,
   parameter int HWY_MIN_GREEN   = 4,
   parameter int CNTRY_MAX_GREEN = 10
) (
   input  logic                                clock,
   input  logic                                clear_n,
   traffic_signal_controller_param_if.slave    bus
);

   // Largest value the timer can hold
   localparam int L_CNT_MAX = (CNT_W >= 31) ? 0 : ((1 << CNT_W) - 1);

   // Parameter legality, evaluated at elaboration
   if (CNT_W < 1 || CNT_W > 30) begin : g_chk_cnt_w
      $error("CNT_W must be in 1..30");
   end
   if (Y2R_DELAY < 1 || Y2R_DELAY > L_CNT_MAX) begin : g_chk_y2r
      $error("Y2R_DELAY must be in 1..2**CNT_W-1");
   end
   if (R2G_DELAY < 1 || R2G_DELAY > L_CNT_MAX) begin : g_chk_r2g
      $error("R2G_DELAY must be in 1..2**CNT_W-1");
   end
   if (HWY_MIN_GREEN < 1 || HWY_MIN_GREEN > L_CNT_MAX) begin : g_chk_hmg
      $error("HWY_MIN_GREEN must be in 1..2**CNT_W-1");
   end
   if (CNTRY_MAX_GREEN < 0 || CNTRY_MAX_GREEN > L_CNT_MAX) begin : g_chk_cmg
      $error("CNTRY_MAX_GREEN must be in 0..2**CNT_W-1");
   end

   // Timer values on the last cycle of each timed phase. The timer reads 0
   // in the first cycle, so a phase of N cycles ends when the timer is N-1.
   localparam logic [CNT_W-1:0] L_Y2R_LAST = CNT_W'(Y2R_DELAY - 1);
   localparam logic [CNT_W-1:0] L_R2G_LAST = CNT_W'(R2G_DELAY - 1);
   localparam logic [CNT_W-1:0] L_HMG_LAST = CNT_W'(HWY_MIN_GREEN - 1);
   localparam logic [CNT_W-1:0] L_CMG_LAST =
      (CNTRY_MAX_GREEN > 0) ? CNT_W'(CNTRY_MAX_GREEN - 1) : '0;
   localparam bit               L_TO_EN    = (CNTRY_MAX_GREEN != 0);

   state_t           r_state;
   state_t           w_next;
   logic             r_timeout;
   logic             w_timeout_next;
   logic             w_restart;
   logic             w_to_hit;
   logic [CNT_W-1:0] w_count;
   lamps_t           w_lamps;

   // Timer restarts on every state change so each phase counts from 0
   assign w_restart = (w_next != r_state);

   phase_timer #(
      .CNT_W (CNT_W)
   ) u_phase_timer (
      .clock   (clock),
      .clear_n (clear_n),
      .restart (w_restart),
      .count   (w_count)
   );

   assign w_to_hit = L_TO_EN && (w_count == L_CMG_LAST);

   // State and timeout-pulse registers
   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) begin
         r_state   <= HG;
         r_timeout <= 1'b0;
      end else begin
         r_state   <= w_next;
         r_timeout <= w_timeout_next;
      end
   end

   // Next-state and Moore lamp decode. X is only looked at in HG and CG.
   always_comb begin
      w_next         = HG;
      w_timeout_next = 1'b0;
      w_lamps        = decode_lamps(r_state);
      case (r_state)
         HG: begin
            // Minimum green also applies right after a timeout, since the
            // timer was restarted on HG entry.
            w_next = (bus.X && (w_count >= L_HMG_LAST)) ? HY : HG;
         end
         HY: begin
            w_next = (w_count == L_Y2R_LAST) ? AR1 : HY;
         end
         AR1: begin
            w_next = (w_count == L_R2G_LAST) ? CG : AR1;
         end
         CG: begin
            if (!bus.X) begin
               // Car gone: normal exit, even if the timeout hits on this
               // same edge, so no pulse.
               w_next = CY;
            end else if (w_to_hit) begin
               w_next         = CY;
               w_timeout_next = 1'b1;
            end else begin
               w_next = CG;
            end
         end
         CY: begin
            w_next = (w_count == L_Y2R_LAST) ? AR2 : CY;
         end
         AR2: begin
            w_next = (w_count == L_R2G_LAST) ? HG : AR2;
         end
         default: begin
            // Unused encodings recover to highway green on the next edge
            w_next = HG;
         end
      endcase
   end

   assign bus.hwy     = w_lamps.hwy;
   assign bus.cntry   = w_lamps.cntry;
   assign bus.phase   = r_state;
   assign bus.timeout = r_timeout;

endmodule

// File: tb/tb_traffic_signal_controller_param.sv
// ----------------------------------------------------------------------------
// Bench for traffic_signal_controller_param. Three instances cover the
// default timing, a disabled country timeout, and a narrow timer with short
// yellow / long clearance. Each stimulus cycle pushes the hand-derived
// expected phase and timeout into a queue; a monitor on the falling edge
// pops and compares against the selected instance.
// ----------------------------------------------------------------------------
module tb_traffic_signal_controller_param;

   logic clk  = 1'b0;
   logic clr0 = 1'b0;
   logic clr1 = 1'b0;
   logic clr2 = 1'b0;

   always #5 clk = ~clk;

   traffic_signal_controller_param_if if0 ();
   traffic_signal_controller_param_if if1 ();
   traffic_signal_controller_param_if if2 ();

   // Default timing: Y2R=3, R2G=2, min green 4, max country green 10
   traffic_signal_controller_param u0 (
      .clock   (clk),
      .clear_n (clr0),
      .bus     (if0.slave)
   );

   // Country timeout disabled
   traffic_signal_controller_param #(
      .CNTRY_MAX_GREEN (0)
   ) u1 (
      .clock   (clk),
      .clear_n (clr1),
      .bus     (if1.slave)
   );

   // 3-bit timer, 1-cycle yellow, 5-cycle all-red
   traffic_signal_controller_param #(
      .CNT_W           (3),
      .Y2R_DELAY       (1),
      .R2G_DELAY       (5),
      .HWY_MIN_GREEN   (4),
      .CNTRY_MAX_GREEN (6)
   ) u2 (
      .clock   (clk),
      .clear_n (clr2),
      .bus     (if2.slave)
   );

   typedef struct {
      int         sel;
      logic [2:0] ph;
      logic       to;
      string      tag;
   } exp_t;

   exp_t q[$];
   int   n_checks = 0;
   int   n_errors = 0;

   // Lamp codes required for each phase: RED=0, YELLOW=1, GREEN=2
   function automatic logic [1:0] req_hwy(input logic [2:0] ph);
      case (ph)
         3'd0:    return 2'd2;
         3'd1:    return 2'd1;
         default: return 2'd0;
      endcase
   endfunction

   function automatic logic [1:0] req_cntry(input logic [2:0] ph);
      case (ph)
         3'd3:    return 2'd2;
         3'd4:    return 2'd1;
         default: return 2'd0;
      endcase
   endfunction

   // One stimulus cycle: just after the rising edge, drive reset and X for
   // the chosen instance and queue what it must show during this cycle.
   task automatic cyc(input string tag, input int sel, input logic clr,
                      input logic x, input logic [2:0] ph, input logic to);
      exp_t e;
      @(posedge clk);
      #1;
      case (sel)
         0:       begin clr0 = clr; if0.X = x; end
         1:       begin clr1 = clr; if1.X = x; end
         default: begin clr2 = clr; if2.X = x; end
      endcase
      e.sel = sel;
      e.ph  = ph;
      e.to  = to;
      e.tag = tag;
      q.push_back(e);
   endtask

   task automatic seg(input string tag, input int sel, input logic clr,
                      input logic x, input logic [2:0] ph, input logic to,
                      input int n);
      for (int i = 0; i < n; i++) cyc(tag, sel, clr, x, ph, to);
   endtask

   // Monitor / scoreboard
   always @(negedge clk) begin : mon
      exp_t       e;
      logic [7:0] act;
      logic [7:0] req;
      if (q.size() != 0) begin
         e = q.pop_front();
         case (e.sel)
            0:       act = {if0.hwy, if0.cntry, if0.phase, if0.timeout};
            1:       act = {if1.hwy, if1.cntry, if1.phase, if1.timeout};
            default: act = {if2.hwy, if2.cntry, if2.phase, if2.timeout};
         endcase
         req = {req_hwy(e.ph), req_cntry(e.ph), e.ph, e.to};
         n_checks++;
         if (act !== req) begin
            n_errors++;
            $display("FAIL %s dut%0d @%0t: got hwy=%0d cntry=%0d phase=%0d timeout=%0d, required hwy=%0d cntry=%0d phase=%0d timeout=%0d",
                     e.tag, e.sel, $time, act[7:6], act[5:4], act[3:1], act[0],
                     req[7:6], req[5:4], req[3:1], req[0]);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      if0.X = 1'b0;
      if1.X = 1'b0;
      if2.X = 1'b0;

      // ---------------- instance 0: default timing ----------------
      // Reset and idle
      seg("rst_hold", 0, 0, 0, 3'd0, 0, 3);
      seg("idle",     0, 1, 0, 3'd0, 0, 20);

      // Minimum green with X high from release
      seg("mg_rst",   0, 0, 1, 3'd0, 0, 2);
      seg("mg_hg",    0, 1, 1, 3'd0, 0, 4);
      seg("mg_hy",    0, 1, 1, 3'd1, 0, 3);
      seg("mg_ar1",   0, 1, 1, 3'd2, 0, 2);

      // X stays high: country green cut at 10 cycles, pulse on first CY
      seg("to_cg",    0, 1, 1, 3'd3, 0, 10);
      seg("to_cy1",   0, 1, 1, 3'd4, 1, 1);
      seg("to_cy",    0, 1, 1, 3'd4, 0, 2);
      seg("to_ar2",   0, 1, 1, 3'd5, 0, 2);
      seg("to_hg",    0, 1, 1, 3'd0, 0, 4);
      seg("to_hy",    0, 1, 1, 3'd1, 0, 3);
      seg("to_ar1",   0, 1, 1, 3'd2, 0, 2);

      // X falls on the same edge as the timeout: no pulse
      seg("tx_cg",    0, 1, 1, 3'd3, 0, 9);
      seg("tx_cg10",  0, 1, 0, 3'd3, 0, 1);
      seg("tx_cy",    0, 1, 0, 3'd4, 0, 3);
      seg("tx_ar2",   0, 1, 0, 3'd5, 0, 2);

      // Normal cycle: X after 10 HG cycles, dropped on 5th CG cycle
      seg("nc_hg",    0, 1, 0, 3'd0, 0, 10);
      seg("nc_hgx",   0, 1, 1, 3'd0, 0, 1);
      seg("nc_hy",    0, 1, 1, 3'd1, 0, 3);
      seg("nc_ar1",   0, 1, 1, 3'd2, 0, 2);
      seg("nc_cg",    0, 1, 1, 3'd3, 0, 4);
      seg("nc_cg5",   0, 1, 0, 3'd3, 0, 1);
      seg("nc_cy",    0, 1, 0, 3'd4, 0, 3);
      seg("nc_ar2",   0, 1, 0, 3'd5, 0, 2);
      seg("nc_hg2",   0, 1, 0, 3'd0, 0, 3);

      // X ignored outside HG/CG; single-cycle country green
      seg("ig_hg",    0, 1, 1, 3'd0, 0, 1);
      seg("ig_hy",    0, 1, 0, 3'd1, 0, 3);
      seg("ig_ar1",   0, 1, 0, 3'd2, 0, 2);
      seg("ig_cg",    0, 1, 0, 3'd3, 0, 1);
      seg("ig_cy",    0, 1, 1, 3'd4, 0, 3);
      seg("ig_ar2",   0, 1, 1, 3'd5, 0, 2);
      seg("ig_hg2",   0, 1, 1, 3'd0, 0, 4);
      seg("ig_hy2",   0, 1, 1, 3'd1, 0, 1);

      // ---------------- instance 1: timeout disabled ----------------
      seg("nt_rst",   1, 0, 1, 3'd0, 0, 2);
      seg("nt_hg",    1, 1, 1, 3'd0, 0, 4);
      seg("nt_hy",    1, 1, 1, 3'd1, 0, 3);
      seg("nt_ar1",   1, 1, 1, 3'd2, 0, 2);
      seg("nt_cg",    1, 1, 1, 3'd3, 0, 100);
      // Reset dropped mid-cycle during CG: lamps go HG before the next edge
      seg("nt_arst",  1, 0, 1, 3'd0, 0, 2);
      seg("nt_rel",   1, 1, 0, 3'd0, 0, 3);

      // ---------------- instance 2: CNT_W=3, Y2R=1, R2G=5 ----------------
      seg("p_rst",    2, 0, 0, 3'd0, 0, 2);
      seg("p_hg",     2, 1, 0, 3'd0, 0, 17);
      // Timer must sit saturated at 7 here; a wrapped timer would read 1
      seg("p_hgx",    2, 1, 1, 3'd0, 0, 1);
      seg("p_hy",     2, 1, 1, 3'd1, 0, 1);
      seg("p_ar1",    2, 1, 1, 3'd2, 0, 5);
      seg("p_cg",     2, 1, 1, 3'd3, 0, 2);
      seg("p_cg3",    2, 1, 0, 3'd3, 0, 1);
      seg("p_cy",     2, 1, 0, 3'd4, 0, 1);
      seg("p_ar2",    2, 1, 0, 3'd5, 0, 5);
      seg("p_hg2",    2, 1, 0, 3'd0, 0, 3);

      // Drain the scoreboard within a bounded number of cycles
      for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clk);
      @(posedge clk);
      n_checks++;
      if (q.size() != 0) begin
         n_errors++;
         $display("FAIL drain: %0d entries left, required 0", q.size());
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
